spi_adc_responder: RTL



---
 rtl/spi_adc_pkg.sv | 19 +
 rtl/spi_adc_responder_if.sv | 27 ++
 rtl/sync_edge_det.sv | 36 +++
 rtl/spi_adc_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/spi_adc_pkg.sv
// Shared constants and types for the SPI ADC128S-style responder.
//   CH_W        : width of the channel field in a command frame
//   CMD_CH_MSB/ : bit positions of the channel field inside the received frame
//   CMD_CH_LSB
//   RESP_PAD_W  : number of bits above the conversion result in a response word
//   spi_st_t    : responder FSM state
package spi_adc_pkg;

    localparam int unsigned CH_W       = 3;
    localparam int unsigned CMD_CH_MSB = 13;
    localparam int unsigned CMD_CH_LSB = 11;
    localparam int unsigned RESP_PAD_W = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } spi_st_t;

endpackage

// File: rtl/spi_adc_responder_if.sv
// SPI link between the A2D master and the ADC responder.
//   SS_n : slave select, active low (master -> slave)
//   SCLK : serial clock, idles high (master -> slave)
//   MOSI : command bits (master -> slave)
//   MISO : response bits (slave -> master)
interface spi_adc_responder_if;

    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO
    );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus a history flop for an asynchronous input.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   din   : asynchronous input
//   level : synchronised level
//   rise  : one-clk pulse on a synchronised 0->1 transition
//   fall  : one-clk pulse on a synchronised 1->0 transition
// RST_VAL should match the idle level of the pin so that reset release does
// not fabricate an edge.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // [0],[1] synchroniser, [2] history
    logic [2:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= {3{RST_VAL}};
        end else begin
            sr_q <= {sr_q[1:0], din};
        end
    end

    assign level = sr_q[1];
    assign rise  = sr_q[1] & ~sr_q[2];
    assign fall  = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder mimicking an ADC128S 8-channel 12-bit converter.
// Each 16-bit frame returns the value of the channel addressed by the previous
// complete frame, taken from the parallel ch_data bus at the start of the frame.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   spi      : SPI link (slave modport)
//   ch_data  : packed channel values, channel n at [n*DATA_W +: DATA_W]
//   cmd_vld  : one-clk pulse when a complete frame ends
//   cmd_chan : channel decoded from the last complete frame
//   frm_err  : one-clk pulse when a frame ends short of FRAME_BITS SCLK rises
// Build option ADC_CHAN_TAG_EN: response bits [15:12] carry {1'b1, channel}
// instead of zeros.
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_adc_responder_if.slave       spi,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     cmd_vld,
    output logic [CH_W-1:0]          cmd_chan,
    output logic                     frm_err
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic unused_lvl;

    // Both pins idle high, so their synchronisers reset high.
    sync_edge_det #(.RST_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (spi.SS_n),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    sync_edge_det #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (spi.SCLK),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    assign unused_lvl = ss_lvl ^ sclk_lvl;

    // MOSI needs only its level, delayed to line up with the SCLK edge pulses.
    logic [1:0] mosi_sr_q;
    logic       mosi_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sr_q <= '0;
        end else begin
            mosi_sr_q <= {mosi_sr_q[0], spi.MOSI};
        end
    end

    assign mosi_sync = mosi_sr_q[1];

    // Response word for the channel chosen by the previous complete frame.
    logic [DATA_W-1:0]     ch_sel;
    logic [RESP_PAD_W-1:0] resp_pad;
    logic [FRAME_BITS-1:0] resp_word;

    always_comb begin
        ch_sel = ch_data[cmd_chan*DATA_W +: DATA_W];
`ifdef ADC_CHAN_TAG_EN
        resp_pad = {1'b1, cmd_chan};
`else
        resp_pad = '0;
`endif
        resp_word = {resp_pad, ch_sel};
    end

    spi_st_t               state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] rx_shr_q, rx_shr_d;
    logic [FRAME_BITS-1:0] tx_shr_q, tx_shr_d;
    logic [CH_W-1:0]       cmd_chan_q, cmd_chan_d;
    logic                  cmd_vld_q, cmd_vld_d;
    logic                  frm_err_q, frm_err_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shr_d   = rx_shr_q;
        tx_shr_d   = tx_shr_q;
        cmd_chan_d = cmd_chan_q;
        cmd_vld_d  = 1'b0;
        frm_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    tx_shr_d  = resp_word;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shr_d = {rx_shr_q[FRAME_BITS-2:0], mosi_sync};
                    if (bit_cnt_q != FRAME_CNT) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                // No shift before the first rise: the MSB must be held for it.
                if (sclk_fall && (bit_cnt_q != '0)) begin
                    tx_shr_d = {tx_shr_q[FRAME_BITS-2:0], 1'b0};
                end
                // Frame end sees the effect of a coincident SCLK rise.
                if (ss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_d == FRAME_CNT) begin
                        cmd_chan_d = rx_shr_d[CMD_CH_MSB:CMD_CH_LSB];
                        cmd_vld_d  = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shr_q   <= '0;
            tx_shr_q   <= '0;
            cmd_chan_q <= '0;
            cmd_vld_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shr_q   <= rx_shr_d;
            tx_shr_q   <= tx_shr_d;
            cmd_chan_q <= cmd_chan_d;
            cmd_vld_q  <= cmd_vld_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign spi.MISO = (state_q == SHIFT) ? tx_shr_q[FRAME_BITS-1] : 1'b0;
    assign cmd_chan = cmd_chan_q;
    assign cmd_vld  = cmd_vld_q;
    assign frm_err  = frm_err_q;

endmodule
